// File: rtl/gpio_bank_if.sv
// CPU I/O bus port of gpio_bank: byte address, write strobe and data, registered read data.
interface gpio_bank_if;
    logic [15:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output wr, output wdata, input rdata);
    modport slave  (input addr, input wr, input wdata, output rdata);
endinterface

// File: rtl/gpio_bank.sv
// Word-mapped GPIO bank: OUT/DIR with atomic set/clear/toggle and 2-flop input sync.
// Define GPIO_EDGE_EN to build edge capture (RISE_EN, FALL_EN, EVENT, IRQ_EN) and irq.
module gpio_bank #(
    parameter int unsigned N    = 54,
    parameter logic [15:0] BASE = 16'h0200
) (
    input  logic         clk,
    input  logic         resetq,
    gpio_bank_if.slave   bus,
    input  logic [N-1:0] pin_in,
    output logic [N-1:0] pin_out,
    output logic [N-1:0] pin_oe,
    output logic         irq
);

    typedef enum logic [3:0] {
        REG_IN      = 4'd0,
        REG_OUT     = 4'd1,
        REG_SET     = 4'd2,
        REG_CLR     = 4'd3,
        REG_TGL     = 4'd4,
        REG_DIR     = 4'd5,
        REG_RISE_EN = 4'd6,
        REG_FALL_EN = 4'd7,
        REG_EVENT   = 4'd8,
        REG_IRQ_EN  = 4'd9
    } reg_idx_e;

    logic         hit;
    logic         wr_hit;
    logic [3:0]   idx;
    logic [6:0]   shamt;
    logic [N-1:0] word_mask;
    logic [N-1:0] word_data;
    logic [31:0]  rd_word;
    logic [N-1:0] out_q;
    logic [N-1:0] dir_q;
    logic [N-1:0] sync1_q;
    logic [N-1:0] sync2_q;
    logic         unused_addr_lsbs;

    assign hit              = bus.addr[15:8] == BASE[15:8];
    assign wr_hit           = bus.wr & hit;
    assign idx              = bus.addr[7:4];
    assign shamt            = {bus.addr[3:2], 5'd0};
    assign unused_addr_lsbs = ^bus.addr[1:0];

    // Bits at or above N drop out in the truncation, so the top word is naturally partial.
    assign word_mask = N'({96'd0, 32'hFFFF_FFFF} << shamt);
    assign word_data = N'({96'd0, bus.wdata} << shamt);

    assign pin_out = out_q;
    assign pin_oe  = dir_q;

    function automatic logic [31:0] word_of(input logic [N-1:0] r, input logic [6:0] s);
        return 32'(128'(r) >> s);
    endfunction

    // NOTE: state flops use <= so every right-hand side sees the pre-edge value.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            out_q   <= '0;
            dir_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= pin_in;
            sync2_q <= sync1_q;
            if (wr_hit) begin
                case (idx)
                    REG_OUT: out_q <= (out_q & ~word_mask) | word_data;
                    REG_SET: out_q <= out_q | word_data;
                    REG_CLR: out_q <= out_q & ~word_data;
                    REG_TGL: out_q <= out_q ^ word_data;
                    REG_DIR: dir_q <= (dir_q & ~word_mask) | word_data;
                    default: ;
                endcase
            end
        end
    end

`ifdef GPIO_EDGE_EN
    logic [N-1:0] prev_q;
    logic [N-1:0] rise_en_q;
    logic [N-1:0] fall_en_q;
    logic [N-1:0] event_q;
    logic [N-1:0] irq_en_q;
    logic [N-1:0] ev_set;
    logic [N-1:0] ev_clr;

    assign ev_set = (sync2_q & ~prev_q & rise_en_q) | (~sync2_q & prev_q & fall_en_q);
    assign ev_clr = (wr_hit && idx == REG_EVENT) ? word_data : '0;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            prev_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            event_q   <= '0;
            irq_en_q  <= '0;
            irq       <= 1'b0;
        end else begin
            prev_q  <= sync2_q;
            irq     <= |(event_q & irq_en_q);
            // A hardware set wins over a W1C of the same bit in the same cycle.
            event_q <= (event_q & ~ev_clr) | ev_set;
            if (wr_hit && idx == REG_RISE_EN) rise_en_q <= (rise_en_q & ~word_mask) | word_data;
            if (wr_hit && idx == REG_FALL_EN) fall_en_q <= (fall_en_q & ~word_mask) | word_data;
            if (wr_hit && idx == REG_IRQ_EN)  irq_en_q  <= (irq_en_q & ~word_mask) | word_data;
        end
    end
`else
    assign irq = 1'b0;
`endif

    // NOTE: rd_word gets a default first so this always_comb cannot infer a latch.
    always_comb begin
        rd_word = '0;
        if (hit) begin
            case (idx)
                REG_IN:      rd_word = word_of(sync2_q, shamt);
                REG_OUT:     rd_word = word_of(out_q, shamt);
                REG_DIR:     rd_word = word_of(dir_q, shamt);
`ifdef GPIO_EDGE_EN
                REG_RISE_EN: rd_word = word_of(rise_en_q, shamt);
                REG_FALL_EN: rd_word = word_of(fall_en_q, shamt);
                REG_EVENT:   rd_word = word_of(event_q, shamt);
                REG_IRQ_EN:  rd_word = word_of(irq_en_q, shamt);
`endif
                default:     rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) bus.rdata <= '0;
        else         bus.rdata <= rd_word;
    end

endmodule
